// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Producer-side hazard controller for the 5-stage in-order core. Covers the
//   hazards the bypass network cannot: load-use, multi-cycle divide,
//   data-memory wait and EX-stage branch redirect. Stall/flush outputs are
//   combinational from registered state plus current inputs (zero latency).
//
// Ports
//   clk, rstn                 core clock, async active-low reset
//   rs1_d, rs2_d              ID-stage source registers
//   rs1_used_d, rs2_used_d    ID instruction reads rs1 / rs2
//   rd_e, regwrite_e          EX-stage destination and write enable
//   memread_e                 EX instruction is a load
//   div_start_e               divide op in EX (held while EX is stalled)
//   div_done                  divider result valid this cycle
//   mem_req_m, mem_ready_m    MEM-stage access and its completion
//   br_redirect_e             EX branch/jump redirects fetch
//   stall_f/d/e/m             hold PC, IF/ID, ID/EX, EX/MEM
//   flush_d/e/m/w             bubble IF/ID, ID/EX, EX/MEM, MEM/WB at next edge
//   stall_cnt                 saturating count of cycles with stall_f=1
//   div_timeout               sticky divider watchdog flag
//
// state    | meaning
// IDLE     | no divide outstanding
// DIV_BUSY | divide accepted, waiting for div_done

module hazard_stall_unit #(
  parameter int CNT_W       = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [4:0]       rd_e,
  input  logic             regwrite_e,
  input  logic             memread_e,
  input  logic             div_start_e,
  input  logic             div_done,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  input  logic             br_redirect_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             div_timeout
);

  localparam int DCW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [DCW-1:0] DIV_MAX  = DCW'(DIV_TIMEOUT);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic           redirect_pend, redirect_pend_nxt;
  logic [DCW-1:0] div_cyc;

  logic mem_wait, divwait, hold_e, redir, load_use;

  always_comb begin
    stall_f           = 1'b0;
    stall_d           = 1'b0;
    stall_e           = 1'b0;
    stall_m           = 1'b0;
    flush_d           = 1'b0;
    flush_e           = 1'b0;
    flush_m           = 1'b0;
    flush_w           = 1'b0;
    state_nxt         = state;

    mem_wait = mem_req_m & ~mem_ready_m;
    divwait  = ((state == DIV_BUSY) | ((state == IDLE) & div_start_e)) & ~div_done;
    hold_e   = mem_wait | divwait;
    // A redirect seen while EX is held is remembered and issued once EX moves.
    redir    = (br_redirect_e | redirect_pend) & ~hold_e;
    load_use = memread_e & regwrite_e & (rd_e != 5'd0) &
               ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));

    // Everything is gated by rstn so the outputs are quiet during reset even
    // while the hazard inputs are still active.
    if (rstn) begin
      if (mem_wait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (divwait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (redir) begin
        // ID holds a wrong-path instruction, so any load-use match is moot.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end

    redirect_pend_nxt = hold_e ? (redirect_pend | br_redirect_e) : 1'b0;

    case (state)
      IDLE:     if (div_start_e & ~div_done & ~mem_wait) state_nxt = DIV_BUSY;
      DIV_BUSY: if (div_done & ~mem_wait)                state_nxt = IDLE;
      default:                                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      redirect_pend <= 1'b0;
      div_cyc       <= '0;
      div_timeout   <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= redirect_pend_nxt;

      if ((state == IDLE) && (state_nxt == DIV_BUSY)) begin
        div_cyc <= '0;
      end else if ((state == DIV_BUSY) && (div_cyc != DIV_MAX)) begin
        div_cyc <= div_cyc + 1'b1;
      end

      // Sets on the edge where div_cyc reaches DIV_TIMEOUT.
      if ((state == DIV_BUSY) && (div_cyc == DIV_LAST)) begin
        div_timeout <= 1'b1;
      end

      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Directed-vector bench with a scoreboard. Each stimulus cycle pushes the
//   hand-computed expected outputs for that cycle; a monitor pops and
//   compares on the falling edge.

module tb_hazard_stall_unit;

  localparam int CNT_W = 32;

  // Expected control word: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] DIV  = 8'b1110_0010;
  localparam logic [7:0] MEM  = 8'b1111_0001;
  localparam logic [7:0] BR   = 8'b0000_1100;

  logic clk, rstn;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic rs1_used_d, rs2_used_d, regwrite_e, memread_e;
  logic div_start_e, div_done, mem_req_m, mem_ready_m, br_redirect_e;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic [CNT_W-1:0] stall_cnt;
  logic div_timeout;

  hazard_stall_unit #(.CNT_W(CNT_W), .DIV_TIMEOUT(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_used_d   (rs1_used_d),
    .rs2_used_d   (rs2_used_d),
    .rd_e         (rd_e),
    .regwrite_e   (regwrite_e),
    .memread_e    (memread_e),
    .div_start_e  (div_start_e),
    .div_done     (div_done),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .br_redirect_e(br_redirect_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_m      (flush_m),
    .flush_w      (flush_w),
    .stall_cnt    (stall_cnt),
    .div_timeout  (div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0]       ctl;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt);
        end
        checks++;
        if (div_timeout !== e.to) begin
          errors++;
          $display("FAIL %s div_timeout: got %b expected %b", e.name, div_timeout, e.to);
        end
      end
    end
  end

  // Inputs for this cycle are already applied; record expectation and advance.
  task automatic cyc(input string n, input logic [7:0] c, input int k, input logic t);
    exp_t e;
    e.name = n;
    e.ctl  = c;
    e.cnt  = CNT_W'(k);
    e.to   = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    rs1_used_d = 0; rs2_used_d = 0; regwrite_e = 0; memread_e = 0;
    div_start_e = 0; div_done = 0; mem_req_m = 0; mem_ready_m = 0;
    br_redirect_e = 0;
  endtask

  task automatic load_x5();
    memread_e = 1; regwrite_e = 1; rd_e = 5'd5;
  endtask

  initial begin
    int wait_cyc;
    clr();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", NONE, 0, 0);
    rstn = 1'b1;

    // Load-use through rs2, then the load moves on.
    load_x5(); rs2_d = 5'd5; rs2_used_d = 1;
    cyc("lu_rs2", LU, 0, 0);
    memread_e = 0;
    cyc("lu_after", NONE, 1, 0);
    // x0 and unused-source never hazard.
    load_x5(); rd_e = 5'd0; rs2_d = 5'd0; rs2_used_d = 1;
    cyc("lu_x0", NONE, 1, 0);
    load_x5(); rs2_d = 5'd5; rs2_used_d = 0;
    cyc("lu_unused", NONE, 1, 0);
    // Load-use through rs1.
    clr(); load_x5(); rs1_d = 5'd5; rs1_used_d = 1;
    cyc("lu_rs1", LU, 1, 0);
    clr();
    cyc("lu_rs1_after", NONE, 2, 0);

    // Five-cycle divide; with DIV_TIMEOUT=4 the watchdog trips on the way.
    div_start_e = 1;
    cyc("div_c1", DIV, 2, 0);
    cyc("div_c2", DIV, 3, 0);
    cyc("div_c3", DIV, 4, 0);
    cyc("div_c4", DIV, 5, 0);
    cyc("div_c5", DIV, 6, 0);
    div_done = 1;
    cyc("div_done", NONE, 7, 1);
    clr();
    cyc("div_idle", NONE, 7, 1);

    // Fast-path divide: no stall, FSM stays idle.
    div_start_e = 1; div_done = 1;
    cyc("div_fast", NONE, 7, 1);
    clr();
    cyc("div_fast_idle", NONE, 7, 1);

    // Branch during a three-cycle memory wait.
    mem_req_m = 1; mem_ready_m = 0; br_redirect_e = 1;
    cyc("br_mw1", MEM, 7, 1);
    cyc("br_mw2", MEM, 8, 1);
    cyc("br_mw3", MEM, 9, 1);
    mem_ready_m = 1;
    cyc("br_ready", BR, 10, 1);
    clr();
    cyc("br_pend_clr", NONE, 10, 1);
    // Redirect suppresses load-use.
    br_redirect_e = 1; load_x5(); rs2_d = 5'd5; rs2_used_d = 1;
    cyc("br_over_lu", BR, 10, 1);
    clr();
    cyc("br_over_lu_after", NONE, 10, 1);

    // Memory wait outranks divide and freezes the FSM in both states.
    div_start_e = 1; mem_req_m = 1; mem_ready_m = 0;
    cyc("mw_idle_div", MEM, 10, 1);
    mem_req_m = 0;
    cyc("div_enter", DIV, 11, 1);
    mem_req_m = 1; div_done = 1;
    cyc("mw_busy_done", MEM, 12, 1);
    mem_req_m = 0;
    cyc("div_exit", NONE, 13, 1);
    clr();
    cyc("div_exit_idle", NONE, 13, 1);

    // Reset clears counter and sticky flag.
    rstn = 1'b0;
    cyc("rst_pulse", NONE, 0, 0);
    rstn = 1'b1;
    cyc("rst_release", NONE, 0, 0);

    // Divide that never completes: watchdog after the 4th DIV_BUSY cycle.
    div_start_e = 1;
    cyc("to_c1", DIV, 0, 0);
    cyc("to_c2", DIV, 1, 0);
    cyc("to_c3", DIV, 2, 0);
    cyc("to_c4", DIV, 3, 0);
    cyc("to_c5", DIV, 4, 0);
    cyc("to_c6", DIV, 5, 1);
    cyc("to_c7", DIV, 6, 1);
    // Reset mid-divide and mid-memory-wait forces outputs low at once.
    rstn = 1'b0;
    cyc("rst_mid_div", NONE, 0, 0);
    mem_req_m = 1; mem_ready_m = 0;
    cyc("rst_mid_mw", NONE, 0, 0);
    rstn = 1'b1;
    clr();
    cyc("rst_idle", NONE, 0, 0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
